// File: rtl/hls_perf_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hls_perf_pkg
//  Desc     : Shared types and constants for the HLS performance monitor.
//  Revision : 1.0 - initial release
// ============================================================================
package hls_perf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } ch_state_e;

  typedef enum logic [2:0] {
    SEL_TXN      = 3'd0,
    SEL_ACTIVE   = 3'd1,
    SEL_STALL    = 3'd2,
    SEL_LAST_LAT = 3'd3,
    SEL_MIN_LAT  = 3'd4,
    SEL_MAX_LAT  = 3'd5,
    SEL_ITER     = 3'd6,
    SEL_STATUS   = 3'd7
  } rd_sel_e;

  // Wide enough for any supported counter width; sliced down per instance.
  localparam int                   MAX_CNT_W    = 64;
  localparam logic [MAX_CNT_W-1:0] MIN_LAT_INIT = '1;

endpackage
`default_nettype wire

// File: rtl/hls_perf_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module   : hls_perf_monitor_if
//  Desc     : Handshake, iteration and register-read bundle of the monitor.
//  Revision : 1.0 - initial release
// ============================================================================
interface hls_perf_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 3,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) ();

  logic              finish;
  logic              clear;
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic [NUM_CH-1:0] iter_start;
  logic              rd_en;
  logic [CH_W-1:0]   rd_chan;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_valid;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] overflow;

  modport master (
    output finish, clear, ap_start, ap_done, ap_continue, iter_start,
           rd_en, rd_chan, rd_sel,
    input  rd_valid, rd_data, busy, overflow
  );

  modport slave (
    input  finish, clear, ap_start, ap_done, ap_continue, iter_start,
           rd_en, rd_chan, rd_sel,
    output rd_valid, rd_data, busy, overflow
  );

endinterface
`default_nettype wire

// File: rtl/hls_perf_monitor_channel.sv
`default_nettype none
// ============================================================================
//  Module   : hls_perf_channel
//  Desc     : One ap_ctrl channel: IDLE/RUN/HOLD tracker plus saturating stats.
//  Revision : 1.0 - initial release
// ============================================================================
module hls_perf_channel
  import hls_perf_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             finish,
  input  wire logic             clear,
  input  wire logic             ap_start,
  input  wire logic             ap_done,
  input  wire logic             ap_continue,
  input  wire logic             iter_start,
  output ch_state_e             state,
  output logic      [CNT_W-1:0] txn_cnt,
  output logic      [CNT_W-1:0] active_cyc,
  output logic      [CNT_W-1:0] stall_cyc,
  output logic      [CNT_W-1:0] last_lat,
  output logic      [CNT_W-1:0] min_lat,
  output logic      [CNT_W-1:0] max_lat,
  output logic      [CNT_W-1:0] iter_cnt,
  output logic                  overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_INIT = MIN_LAT_INIT[CNT_W-1:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  ch_state_e        state_q,      state_d;
  logic [CNT_W-1:0] lat_cnt_q,    lat_cnt_d;
  logic [CNT_W-1:0] txn_cnt_q,    txn_cnt_d;
  logic [CNT_W-1:0] active_cyc_q, active_cyc_d;
  logic [CNT_W-1:0] stall_cyc_q,  stall_cyc_d;
  logic [CNT_W-1:0] last_lat_q,   last_lat_d;
  logic [CNT_W-1:0] min_lat_q,    min_lat_d;
  logic [CNT_W-1:0] max_lat_q,    max_lat_d;
  logic [CNT_W-1:0] iter_cnt_q,   iter_cnt_d;
  logic             overflow_q,   overflow_d;

  logic             w_complete;
  logic [CNT_W-1:0] w_cur_lat;
  logic             w_act_inc;
  logic             w_stall_inc;
  logic             w_iter_inc;
  logic             w_lat_inc;

  // Next state; w_cur_lat is the latency including the current cycle.
  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    w_complete  = 1'b0;
    w_cur_lat   = '0;
    w_act_inc   = 1'b0;
    w_stall_inc = 1'b0;
    w_iter_inc  = 1'b0;
    w_lat_inc   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ap_start) begin
          w_act_inc = 1'b1;
          lat_cnt_d = CNT_ONE;
          if (ap_done && ap_continue) begin
            w_complete = 1'b1;
            w_cur_lat  = CNT_ONE;
          end else if (ap_done) begin
            state_d = HOLD;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        w_act_inc  = 1'b1;
        w_iter_inc = iter_start;
        w_lat_inc  = 1'b1;
        lat_cnt_d  = sat_inc(lat_cnt_q);
        if (ap_done && ap_continue) begin
          w_complete = 1'b1;
          w_cur_lat  = sat_inc(lat_cnt_q);
          if (ap_start) lat_cnt_d = CNT_ONE;
          else          state_d   = IDLE;
        end else if (ap_done) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        w_stall_inc = 1'b1;
        if (ap_continue) begin
          w_complete = 1'b1;
          w_cur_lat  = lat_cnt_q;
          if (ap_start) begin
            state_d   = RUN;
            lat_cnt_d = CNT_ONE;
            w_act_inc = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Statistics; clear discards whatever event lands in the same cycle.
  always_comb begin
    txn_cnt_d    = txn_cnt_q;
    active_cyc_d = active_cyc_q;
    stall_cyc_d  = stall_cyc_q;
    last_lat_d   = last_lat_q;
    min_lat_d    = min_lat_q;
    max_lat_d    = max_lat_q;
    iter_cnt_d   = iter_cnt_q;
    overflow_d   = overflow_q;
    if (clear) begin
      txn_cnt_d    = '0;
      active_cyc_d = '0;
      stall_cyc_d  = '0;
      last_lat_d   = '0;
      min_lat_d    = MIN_INIT;
      max_lat_d    = '0;
      iter_cnt_d   = '0;
      overflow_d   = 1'b0;
    end else begin
      if (w_act_inc)   active_cyc_d = sat_inc(active_cyc_q);
      if (w_stall_inc) stall_cyc_d  = sat_inc(stall_cyc_q);
      if (w_iter_inc)  iter_cnt_d   = sat_inc(iter_cnt_q);
      if (w_complete) begin
        txn_cnt_d  = sat_inc(txn_cnt_q);
        last_lat_d = w_cur_lat;
        if (w_cur_lat < min_lat_q) min_lat_d = w_cur_lat;
        if (w_cur_lat > max_lat_q) max_lat_d = w_cur_lat;
      end
      overflow_d = overflow_q
                 | (w_act_inc   && (active_cyc_q == CNT_MAX))
                 | (w_stall_inc && (stall_cyc_q  == CNT_MAX))
                 | (w_iter_inc  && (iter_cnt_q   == CNT_MAX))
                 | (w_complete  && (txn_cnt_q    == CNT_MAX))
                 | (w_lat_inc   && (lat_cnt_q    == CNT_MAX));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      txn_cnt_q    <= '0;
      active_cyc_q <= '0;
      stall_cyc_q  <= '0;
      last_lat_q   <= '0;
      min_lat_q    <= MIN_INIT;
      max_lat_q    <= '0;
      iter_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else if (!finish) begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      txn_cnt_q    <= txn_cnt_d;
      active_cyc_q <= active_cyc_d;
      stall_cyc_q  <= stall_cyc_d;
      last_lat_q   <= last_lat_d;
      min_lat_q    <= min_lat_d;
      max_lat_q    <= max_lat_d;
      iter_cnt_q   <= iter_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign state      = state_q;
  assign txn_cnt    = txn_cnt_q;
  assign active_cyc = active_cyc_q;
  assign stall_cyc  = stall_cyc_q;
  assign last_lat   = last_lat_q;
  assign min_lat    = min_lat_q;
  assign max_lat    = max_lat_q;
  assign iter_cnt   = iter_cnt_q;
  assign overflow   = overflow_q;

endmodule
`default_nettype wire

// File: rtl/hls_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : hls_perf_monitor
//  Desc     : Multi-channel ap_ctrl statistics monitor with registered read port.
//  Revision : 1.0 - initial release
// ============================================================================
module hls_perf_monitor
  import hls_perf_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 3
) (
  input wire logic          clk,
  input wire logic          rst,
  hls_perf_monitor_if.slave bus
);

  ch_state_e         ch_state   [NUM_CH];
  logic [CNT_W-1:0]  txn_cnt    [NUM_CH];
  logic [CNT_W-1:0]  active_cyc [NUM_CH];
  logic [CNT_W-1:0]  stall_cyc  [NUM_CH];
  logic [CNT_W-1:0]  last_lat   [NUM_CH];
  logic [CNT_W-1:0]  min_lat    [NUM_CH];
  logic [CNT_W-1:0]  max_lat    [NUM_CH];
  logic [CNT_W-1:0]  iter_cnt   [NUM_CH];
  logic [NUM_CH-1:0] w_overflow;
  logic [NUM_CH-1:0] w_busy;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      hls_perf_channel #(
        .CNT_W (CNT_W)
      ) u_channel (
        .clk         (clk),
        .rst         (rst),
        .finish      (bus.finish),
        .clear       (bus.clear),
        .ap_start    (bus.ap_start[i]),
        .ap_done     (bus.ap_done[i]),
        .ap_continue (bus.ap_continue[i]),
        .iter_start  (bus.iter_start[i]),
        .state       (ch_state[i]),
        .txn_cnt     (txn_cnt[i]),
        .active_cyc  (active_cyc[i]),
        .stall_cyc   (stall_cyc[i]),
        .last_lat    (last_lat[i]),
        .min_lat     (min_lat[i]),
        .max_lat     (max_lat[i]),
        .iter_cnt    (iter_cnt[i]),
        .overflow    (w_overflow[i])
      );
      assign w_busy[i] = (ch_state[i] != IDLE);
    end
  endgenerate

  logic [CNT_W-1:0] w_rd_word;
  logic [2:0]       w_status;
  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q,  rd_data_d;

  // Out-of-range channels read as zero rather than aliasing a real channel.
  always_comb begin
    w_rd_word = '0;
    w_status  = '0;
    if (int'(bus.rd_chan) < NUM_CH) begin
      w_status = {w_overflow[bus.rd_chan], ch_state[bus.rd_chan]};
      case (bus.rd_sel)
        SEL_TXN:      w_rd_word = txn_cnt[bus.rd_chan];
        SEL_ACTIVE:   w_rd_word = active_cyc[bus.rd_chan];
        SEL_STALL:    w_rd_word = stall_cyc[bus.rd_chan];
        SEL_LAST_LAT: w_rd_word = last_lat[bus.rd_chan];
        SEL_MIN_LAT:  w_rd_word = min_lat[bus.rd_chan];
        SEL_MAX_LAT:  w_rd_word = max_lat[bus.rd_chan];
        SEL_ITER:     w_rd_word = iter_cnt[bus.rd_chan];
        SEL_STATUS:   w_rd_word = CNT_W'(w_status);
        default:      w_rd_word = '0;
      endcase
    end
  end

  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_data_d  = bus.rd_en ? w_rd_word : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = w_busy;
  assign bus.overflow = w_overflow;

endmodule
`default_nettype wire

// File: tb/tb_hls_perf_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hls_perf_monitor
//  Desc     : Directed bench for hls_perf_monitor (3 channels, 4-bit counters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hls_perf_monitor;
  import hls_perf_pkg::*;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 4;
  localparam int SEL_W  = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  logic [CNT_W-1:0] exp_q[$];
  string            tag_q[$];

  hls_perf_monitor_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) bus ();

  hls_perf_monitor #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .SEL_W(SEL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one read; the expected word goes into the scoreboard, the
  // returned word is popped and compared one cycle later.
  task automatic rd(input int ch, input int sel, input logic [CNT_W-1:0] exp, input string tag);
    logic [CNT_W-1:0] e;
    string            t;
    bus.rd_en   = 1'b1;
    bus.rd_chan = 2'(ch);
    bus.rd_sel  = 3'(sel);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    if (bus.rd_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, 32'(bus.rd_data), 32'(e));
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.finish      = 1'b0;
    bus.clear       = 1'b0;
    bus.ap_start    = '0;
    bus.ap_done     = '0;
    bus.ap_continue = '1;
    bus.iter_start  = '0;
    bus.rd_en       = 1'b0;
    bus.rd_chan     = '0;
    bus.rd_sel      = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    rst = 1'b0;
    rd(0, SEL_TXN, 4'd0, "rst_txn");
    rd(0, SEL_MIN_LAT, 4'hF, "rst_min");
    @(negedge clk);
    chk("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("idle_rd_hold", 32'(bus.rd_data), 32'hF);

    // ch0: start c0, done&continue c9 -> latency 10
    bus.ap_start[0] = 1'b1; @(negedge clk);
    bus.ap_start[0] = 1'b0; repeat (8) @(negedge clk);
    bus.ap_done[0]  = 1'b1; @(negedge clk);
    bus.ap_done[0]  = 1'b0;
    chk("s1_busy", 32'(bus.busy[0]), 32'd0);
    rd(0, SEL_TXN,      4'd1,  "s1_txn");
    rd(0, SEL_LAST_LAT, 4'd10, "s1_last");
    rd(0, SEL_MIN_LAT,  4'd10, "s1_min");
    rd(0, SEL_MAX_LAT,  4'd10, "s1_max");
    rd(0, SEL_ACTIVE,   4'd10, "s1_active");
    rd(0, SEL_STALL,    4'd0,  "s1_stall");

    // ch1: done c5 with continue low c5..c7, high c8 -> three HOLD cycles
    bus.ap_start[1] = 1'b1; @(negedge clk);
    bus.ap_start[1] = 1'b0; repeat (4) @(negedge clk);
    bus.ap_done[1] = 1'b1; bus.ap_continue[1] = 1'b0; @(negedge clk);
    bus.ap_done[1] = 1'b0;
    rd(1, SEL_STATUS, 4'h2, "s2_hold_status");
    @(negedge clk);
    bus.ap_continue[1] = 1'b1; @(negedge clk);
    chk("s2_busy", 32'(bus.busy[1]), 32'd0);
    rd(1, SEL_STALL,    4'd3, "s2_stall");
    rd(1, SEL_LAST_LAT, 4'd6, "s2_last");
    rd(1, SEL_ACTIVE,   4'd6, "s2_active");
    rd(1, SEL_STATUS,   4'h0, "s2_idle_status");

    // ch2: back-to-back, completion c3 with new start, second done c9
    bus.ap_start[2] = 1'b1; bus.iter_start[2] = 1'b1; @(negedge clk);
    bus.ap_start[2] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("s3_busy", 32'(bus.busy[2]), 32'd1);
      bus.iter_start[2] = (c <= 2);
      bus.ap_done[2]    = (c == 3);
      bus.ap_start[2]   = (c == 3);
      @(negedge clk);
    end
    chk("s3_busy", 32'(bus.busy[2]), 32'd1);
    bus.ap_done[2] = 1'b1; @(negedge clk);
    bus.ap_done[2] = 1'b0;
    chk("s3_busy_end", 32'(bus.busy[2]), 32'd0);
    rd(2, SEL_TXN,      4'd2,  "s3_txn");
    rd(2, SEL_MIN_LAT,  4'd4,  "s3_min");
    rd(2, SEL_MAX_LAT,  4'd7,  "s3_max");
    rd(2, SEL_LAST_LAT, 4'd7,  "s3_last");
    rd(2, SEL_ACTIVE,   4'd10, "s3_active");
    rd(2, SEL_ITER,     4'd2,  "s3_iter");
    chk("s3_ovf", 32'(bus.overflow), 32'd0);

    // ch0: 20 iteration pulses in RUN saturate at 15, then clear
    bus.ap_start[0] = 1'b1; bus.iter_start[0] = 1'b1; @(negedge clk);
    bus.ap_start[0] = 1'b0; repeat (20) @(negedge clk);
    bus.iter_start[0] = 1'b0;
    chk("s4_ovf", 32'(bus.overflow[0]), 32'd1);
    rd(0, SEL_ITER, 4'hF, "s4_iter_sat");
    bus.ap_done[0] = 1'b1; @(negedge clk);
    bus.ap_done[0] = 1'b0;
    rd(0, SEL_STATUS, 4'h4, "s4_status_ovf");
    bus.clear = 1'b1; @(negedge clk);
    bus.clear = 1'b0;
    chk("s4_ovf_clr", 32'(bus.overflow), 32'd0);
    rd(0, SEL_ITER,    4'd0, "s4_iter_clr");
    rd(0, SEL_MIN_LAT, 4'hF, "s4_min_clr");
    rd(0, SEL_TXN,     4'd0, "s4_txn_clr");
    rd(0, SEL_STATUS,  4'h0, "s4_status_clr");

    // ch2: finish mid-RUN freezes everything and ignores clear
    bus.ap_start[2] = 1'b1; @(negedge clk);
    bus.ap_start[2] = 1'b0; repeat (2) @(negedge clk);
    bus.finish = 1'b1;
    rd(2, SEL_ACTIVE, 4'd3, "s5_active_frz");
    bus.clear = 1'b1; @(negedge clk);
    bus.clear = 1'b0; repeat (2) @(negedge clk);
    rd(2, SEL_ACTIVE, 4'd3, "s5_active_hold");
    rd(2, SEL_STATUS, 4'h1, "s5_status_run");
    bus.finish = 1'b0;
    rd(3, SEL_TXN, 4'd0, "s5_oob_chan");
    bus.ap_done[2] = 1'b1; @(negedge clk);
    bus.ap_done[2] = 1'b0;
    rd(2, SEL_ACTIVE,   4'd5, "s5_active_end");
    rd(2, SEL_LAST_LAT, 4'd5, "s5_last");

    // ch1: reset while in HOLD aborts the transaction
    bus.ap_start[1] = 1'b1; @(negedge clk);
    bus.ap_start[1] = 1'b0;
    bus.ap_done[1] = 1'b1; bus.ap_continue[1] = 1'b0; @(negedge clk);
    bus.ap_done[1] = 1'b0; @(negedge clk);
    chk("s6_busy_hold", 32'(bus.busy[1]), 32'd1);
    rst = 1'b1; @(negedge clk);
    rst = 1'b0; bus.ap_continue[1] = 1'b1;
    chk("s6_busy_rst", 32'(bus.busy), 32'd0);
    chk("s6_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("s6_rd_data", 32'(bus.rd_data), 32'd0);
    rd(1, SEL_TXN,      4'd0, "s6_txn");
    rd(2, SEL_LAST_LAT, 4'd0, "s6_last");
    rd(1, SEL_MIN_LAT,  4'hF, "s6_min");

    // ch0: clear coincident with completion discards it
    bus.ap_start[0] = 1'b1; @(negedge clk);
    bus.ap_start[0] = 1'b0; @(negedge clk);
    bus.ap_done[0] = 1'b1; bus.clear = 1'b1; @(negedge clk);
    bus.ap_done[0] = 1'b0; bus.clear = 1'b0;
    chk("s7_busy", 32'(bus.busy[0]), 32'd0);
    rd(0, SEL_TXN,      4'd0, "s7_txn");
    rd(0, SEL_MIN_LAT,  4'hF, "s7_min");
    rd(0, SEL_LAST_LAT, 4'd0, "s7_last");

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
